// File: rtl/display_pkg.sv
// Shared constants and FSM state encoding for the frame-buffer line packer.
package display_pkg;

  localparam int unsigned LINE_W            = 54;
  localparam int unsigned BYTES_PER_LINE    = 7;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned IDX_W             = 3;
  localparam int unsigned NUM_LINES_DEFAULT = 3201;
  localparam int unsigned ADDR_W_DEFAULT    = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/line_shreg.sv
// Byte-indexed line assembler: drops a byte into slot idx of a 54-bit line.
// line_c is the next-cycle view so the caller can capture a just-completed line.
module line_shreg
  import display_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              clr,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BYTE_W-1:0] data,
  output logic [LINE_W-1:0] line_c
);

  localparam int HEAD_BYTES = int'(BYTES_PER_LINE) - 1;
  localparam int unsigned TAIL_W = LINE_W - BYTE_W * (BYTES_PER_LINE - 1);

  logic [LINE_W-1:0] line_q;

  // Full bytes fill from the MSB down; the last slot keeps only the byte's top bits.
  always_comb begin
    line_c = line_q;
    if (clr) begin
      line_c = '0;
    end else if (load) begin
      for (int i = 0; i < HEAD_BYTES; i++) begin
        if (idx == IDX_W'(i)) begin
          line_c[LINE_W-1-BYTE_W*i -: BYTE_W] = data;
        end
      end
      if (idx == IDX_W'(HEAD_BYTES)) begin
        line_c[TAIL_W-1:0] = data[BYTE_W-1 -: TAIL_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) line_q <= '0;
    else       line_q <= line_c;
  end

endmodule

// File: rtl/line_packer.sv
// Packs a TFTP byte stream into 54-bit frame-buffer lines, one RAM write per line.
// Optional running checksum on o_csum when LINE_PACKER_CHECKSUM_EN is defined.
module line_packer
  import display_pkg::*;
#(
  parameter int unsigned NUM_LINES = NUM_LINES_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wr,
  output logic [ADDR_W-1:0] addrWrite,
  output logic [LINE_W-1:0] dataLine,
  output logic              o_done,
  output logic              o_ovf,
  output logic [7:0]        o_csum
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] COLLECT = ST_COLLECT;
  localparam logic [1:0] WRITE   = ST_WRITE;
  localparam logic [1:0] DONE    = ST_DONE;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LINES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_LINE - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] line_q, line_d, addr_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [LINE_W-1:0] data_d, shreg_line_c;
  logic              last_term_q, last_term_d;
  logic              ready_q, ready_d;
  logic              wr_d, done_d, ovf_d;
  logic              acc, shreg_clr, shreg_load;

  // A restart request masks the handshake for that cycle.
  assign s_ready    = ready_q & ~i_start & ~i_rst;
  assign acc        = s_valid & s_ready;
  assign shreg_clr  = i_start | (state_q == WRITE);
  assign shreg_load = acc & (state_q == COLLECT);

  line_shreg u_shreg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr    (shreg_clr),
    .load   (shreg_load),
    .idx    (k_q),
    .data   (s_data),
    .line_c (shreg_line_c)
  );

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    k_d         = k_q;
    last_term_d = last_term_q;
    ovf_d       = o_ovf;
    addr_d      = addrWrite;
    data_d      = dataLine;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    if (i_start) begin
      state_d     = COLLECT;
      line_d      = '0;
      k_d         = '0;
      ovf_d       = 1'b0;
      last_term_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (acc) begin
            k_d = k_q + IDX_W'(1);
            if (k_q == LAST_IDX || s_last) begin
              state_d     = WRITE;
              wr_d        = 1'b1;
              addr_d      = line_q;
              data_d      = shreg_line_c;
              last_term_d = s_last;
            end
          end
        end
        WRITE: begin
          k_d = '0;
          // Stop on the final buffer line rather than wrapping the address.
          if (last_term_q || line_q == LAST_ADDR) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            line_d  = line_q + ADDR_W'(1);
            state_d = COLLECT;
          end
        end
        DONE: begin
          if (acc) begin
            if (!last_term_q) ovf_d = 1'b1;
            if (s_last) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
    ready_d = (state_d == COLLECT) || (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      k_q         <= '0;
      last_term_q <= 1'b0;
      ready_q     <= 1'b0;
      wr          <= 1'b0;
      addrWrite   <= '0;
      dataLine    <= '0;
      o_done      <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      k_q         <= k_d;
      last_term_q <= last_term_d;
      ready_q     <= ready_d;
      wr          <= wr_d;
      addrWrite   <= addr_d;
      dataLine    <= data_d;
      o_done      <= done_d;
      o_ovf       <= ovf_d;
    end
  end

`ifdef LINE_PACKER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) csum_q <= '0;
    else if (acc)         csum_q <= csum_q + s_data;
  end

  assign o_csum = csum_q;
`else
  assign o_csum = '0;
`endif

endmodule

// File: tb/tb_line_packer.sv
// Randomized and directed bench for line_packer against a byte-list line model.
module tb_line_packer;

  localparam int NL = 6;
  localparam int AW = 4;

  logic          i_clk   = 1'b0;
  logic          i_rst   = 1'b1;
  logic          i_start = 1'b0;
  logic [7:0]    s_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_last  = 1'b0;
  logic          s_ready;
  logic          wr;
  logic [AW-1:0] addrWrite;
  logic [53:0]   dataLine;
  logic          o_done;
  logic          o_ovf;
  logic [7:0]    o_csum;

  line_packer #(.NUM_LINES(NL), .ADDR_W(AW)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .wr        (wr),
    .addrWrite (addrWrite),
    .dataLine  (dataLine),
    .o_done    (o_done),
    .o_ovf     (o_ovf),
    .o_csum    (o_csum)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wa_q[$];
  logic [53:0] wd_q[$];
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic [7:0] stim[$];

  always @(posedge i_clk) cyc++;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (wr === 1'b1) begin
      wa_q.push_back(int'(addrWrite));
      wd_q.push_back(dataLine);
      last_wr_cyc = cyc;
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    s_data  = b;
    s_last  = last;
    s_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge i_clk);
      if (s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL accept_timeout: observed no s_ready expected s_ready within 20 cycles");
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    i_start = 1'b1;
    #1;
    check("ready_on_start", 64'(s_ready), 64'd0);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // Feeds stim[] as one frame, then compares against the line model.
  task automatic run_frame(input bit with_last);
    int len, nl, idx, sum;
    logic [53:0] e, e_last;
    logic [7:0] b;
    bit completes;
    len = stim.size();
    pulse_start();
    for (int i = 0; i < len; i++) begin
      send_byte(stim[i], with_last && (i == len - 1));
      completes = ((i % 7) == 6) || (with_last && (i == len - 1));
      if (completes && (i / 7) < NL) check("wr_latency", 64'(wr), 64'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (6) @(posedge i_clk);
    #1;
    nl = with_last ? (len + 6) / 7 : len / 7;
    if (nl > NL) nl = NL;
    check("num_writes", 64'(wa_q.size()), 64'(nl));
    e_last = '0;
    for (int j = 0; j < nl; j++) begin
      e = '0;
      for (int i = 0; i < 7; i++) begin
        idx = 7 * j + i;
        if (idx < len) begin
          b = stim[idx];
          if (i < 6) e = e | (54'(b) << (46 - 8 * i));
          else       e = e | 54'(b >> 2);
        end
      end
      e_last = e;
      if (j < wa_q.size()) begin
        check("wr_addr", 64'(wa_q[j]), 64'(j));
        check("wr_data", 64'(wd_q[j]), 64'(e));
      end
    end
    if (nl > 0) check("data_hold", 64'(dataLine), 64'(e_last));
    check("done_count", 64'(done_cnt), (with_last || len >= 7 * NL) ? 64'd1 : 64'd0);
    if (done_cnt > 0) check("done_timing", 64'(done_cyc), 64'(last_wr_cyc + 1));
    check("ovf", 64'(o_ovf), (len > 7 * NL) ? 64'd1 : 64'd0);
    check("addr_bound", 64'(int'(addrWrite) <= NL - 1), 64'd1);
    sum = 0;
    for (int i = 0; i < len; i++) sum += int'(stim[i]);
`ifdef LINE_PACKER_CHECKSUM_EN
    check("csum", 64'(o_csum), 64'(sum % 256));
`else
    check("csum", 64'(o_csum), 64'd0);
`endif
  endtask

  initial begin
    int len;
    bit lst;
    logic [63:0] exp_csum;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    check("rst_csum", 64'(o_csum), 64'd0);
    check("rst_addr", 64'(addrWrite), 64'd0);
    check("rst_data", 64'(dataLine), 64'd0);

    // Seven 0xFF bytes fill one line completely.
    stim.delete();
    repeat (7) stim.push_back(8'hFF);
    run_frame(1'b0);
    if (wd_q.size() > 0) check("all_ones", 64'(wd_q[0]), 64'(54'h3F_FFFF_FFFF_FFFF));

    // Two consecutive lines with a truncated seventh byte.
    stim.delete();
    for (int i = 1; i <= 14; i++) stim.push_back(8'(i));
    run_frame(1'b0);
    if (wd_q.size() > 1) check("second_line", 64'(wd_q[1]), 64'(54'h02_0242_82C3_0343));

    // Short frame terminated by s_last, zero padded.
    stim.delete();
    stim.push_back(8'hAA);
    stim.push_back(8'hBB);
    stim.push_back(8'hCC);
    run_frame(1'b1);
    if (wd_q.size() > 0) check("short_last", 64'(wd_q[0]), 64'(54'h2A_AEF3_0000_0000));

    // Bytes after an s_last-terminated frame are dropped without overflow.
    send_byte(8'h55, 1'b0);
    check("post_last_no_ovf", 64'(o_ovf), 64'd0);
    send_byte(8'h66, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge i_clk);
    #1;
    check("idle_after_last", 64'(s_ready), 64'd0);
    check("no_wr_in_done", 64'(wa_q.size()), 64'd1);

    // Overflow past the last buffer line.
    stim.delete();
    repeat (7 * NL + 1) stim.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b0);

    // Restart mid-line: partial line is dropped, next line goes to address 0.
    stim.delete();
    repeat (7 * (NL - 1) + 4) stim.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b0);
    stim.delete();
    repeat (7) stim.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b0);

    // Checksum wrap.
    stim.delete();
    stim.push_back(8'h80);
    stim.push_back(8'h90);
    run_frame(1'b1);
`ifdef LINE_PACKER_CHECKSUM_EN
    exp_csum = 64'h10;
`else
    exp_csum = 64'h0;
`endif
    check("csum_wrap", 64'(o_csum), exp_csum);

    // Random frames.
    for (int f = 0; f < 10; f++) begin
      len = int'($urandom_range(1, 7 * NL + 2));
      lst = 1'($urandom_range(0, 1));
      stim.delete();
      repeat (len) stim.push_back(8'($urandom_range(0, 255)));
      run_frame(lst);
    end

    // Reset mid-frame, asserted together with i_start.
    pulse_start();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    s_valid = 1'b0;
    i_rst   = 1'b1;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check("rst_mid_no_wr", 64'(wa_q.size()), 64'd0);
    check("rst_mid_addr", 64'(addrWrite), 64'd0);
    check("rst_mid_data", 64'(dataLine), 64'd0);
    check("rst_mid_ready", 64'(s_ready), 64'd0);
    check("rst_mid_ovf", 64'(o_ovf), 64'd0);
    check("rst_mid_csum", 64'(o_csum), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
